if_id_stage: RTL and testbench

//  Parametrised IF/ID pipeline stage for the RV32 pipeline. Registers {instruction, pc, pc+4}.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_slot.sv | 34 +++
 rtl/if_id_stage.sv | 123 ++++++++++++
 tb/tb_if_id_stage.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and types for the IF/ID pipeline stage.
package pipe_pkg;
    localparam int          PIPE_XLEN = 32;
    localparam logic [31:0] PIPE_NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} stage_state_e;

    typedef struct packed {
        logic [PIPE_XLEN-1:0] instr;
        logic [PIPE_XLEN-1:0] pc;
        logic [PIPE_XLEN-1:0] pc_plus4;
    } payload_t;
endpackage

// File: rtl/pipe_slot.sv
// One payload register {instr, pc, pc+4} with valid bit, load enable and clear-to-NOP.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int              XLEN      = PIPE_XLEN,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(PIPE_NOP)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_ld,
    input  logic [3*XLEN-1:0] i_d,
    output logic [3*XLEN-1:0] o_q,
    output logic              o_vld
);
    // An empty slot always holds the NOP pattern so outputs need no masking.
    localparam logic [3*XLEN-1:0] EMPTY_VAL = {NOP_INSTR, {(2*XLEN){1'b0}}};

    logic              r_vld;
    logic [3*XLEN-1:0] r_data;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_vld  <= 1'b0;
            r_data <= EMPTY_VAL;
        end else if (i_ld) begin
            r_vld  <= 1'b1;
            r_data <= i_d;
        end
    end

    assign o_q   = r_data;
    assign o_vld = r_vld;
endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with valid/ready handshake, flush-to-NOP, optional skid
// entry and a saturating stall-cycle counter.
module if_id_stage
    import pipe_pkg::*;
#(
    parameter int              XLEN      = PIPE_XLEN,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(PIPE_NOP),
    parameter bit              SKID      = 1'b1,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  instruction_in,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [XLEN-1:0]  pc_plus4_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  instruction_out,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  pc_plus4_out,
    output logic [CNT_W-1:0] stall_cnt
);
    stage_state_e      r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [3*XLEN-1:0] w_in_data, w_main_d, w_main_q, w_skid_q;
    logic              w_main_vld, w_skid_vld;
    logic              w_accept, w_drain;
    logic              w_main_ld, w_main_clr, w_main_src_skid;
    logic              w_skid_ld, w_skid_clr;

    assign w_in_data = {instruction_in, pc_in, pc_plus4_in};
    assign w_accept  = in_valid && in_ready;
    assign w_drain   = w_main_vld && out_ready;
    assign w_main_d  = w_main_src_skid ? w_skid_q : w_in_data;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_EMPTY;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL: begin
                if (w_accept && !w_drain)      w_state_nxt = ST_SKID;
                else if (!w_accept && w_drain) w_state_nxt = ST_EMPTY;
            end
            ST_SKID:  if (w_drain) w_state_nxt = ST_FULL;
            default:  w_state_nxt = ST_EMPTY;
        endcase
        if (flush) w_state_nxt = ST_EMPTY;
    end

    always_comb begin
        w_main_ld       = 1'b0;
        w_main_clr      = 1'b0;
        w_main_src_skid = 1'b0;
        w_skid_ld       = 1'b0;
        w_skid_clr      = 1'b0;
        if (flush) begin
            w_main_clr = 1'b1;
            w_skid_clr = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: w_main_ld = w_accept;
                ST_FULL: begin
                    w_main_ld  = w_accept && w_drain;
                    w_skid_ld  = w_accept && !w_drain;
                    w_main_clr = !w_accept && w_drain;
                end
                ST_SKID: begin
                    w_main_src_skid = 1'b1;
                    w_main_ld       = w_drain;
                    w_skid_clr      = w_drain;
                end
                default: ;
            endcase
        end
    end

    pipe_slot #(.XLEN(XLEN), .NOP_INSTR(NOP_INSTR)) u_main (
        .i_clk (clk),
        .i_rst (rst),
        .i_clr (w_main_clr),
        .i_ld  (w_main_ld),
        .i_d   (w_main_d),
        .o_q   (w_main_q),
        .o_vld (w_main_vld)
    );

    // With a skid entry in_ready comes straight from a flop, cutting the out_ready path.
    if (SKID) begin : g_skid
        pipe_slot #(.XLEN(XLEN), .NOP_INSTR(NOP_INSTR)) u_skid (
            .i_clk (clk),
            .i_rst (rst),
            .i_clr (w_skid_clr),
            .i_ld  (w_skid_ld),
            .i_d   (w_in_data),
            .o_q   (w_skid_q),
            .o_vld (w_skid_vld)
        );
        assign in_ready = !w_skid_vld;
    end else begin : g_noskid
        assign w_skid_q   = '0;
        assign w_skid_vld = 1'b0;
        assign in_ready   = !w_main_vld || out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (w_main_vld && !out_ready && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign out_valid                                = w_main_vld;
    assign {instruction_out, pc_out, pc_plus4_out}  = w_main_q;
    assign stall_cnt                                = r_stall_cnt;
endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: SKID=1 and SKID=0 instances share stimulus, each with its own scoreboard.
module tb_if_id_stage;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] instruction_in, pc_in, pc_plus4_in;
    logic        in_rdy [2];
    logic        o_vld  [2];
    logic [31:0] o_ins  [2];
    logic [31:0] o_pc   [2];
    logic [31:0] o_pc4  [2];
    logic [3:0]  o_cnt  [2];
    int          n_run  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    if_id_stage #(.SKID(1'b1), .CNT_W(4)) u_skid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_rdy[1]),
        .instruction_in(instruction_in), .pc_in(pc_in), .pc_plus4_in(pc_plus4_in),
        .out_valid(o_vld[1]), .out_ready(out_ready), .instruction_out(o_ins[1]),
        .pc_out(o_pc[1]), .pc_plus4_out(o_pc4[1]), .stall_cnt(o_cnt[1])
    );

    if_id_stage #(.SKID(1'b0), .CNT_W(4)) u_noskid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_rdy[0]),
        .instruction_in(instruction_in), .pc_in(pc_in), .pc_plus4_in(pc_plus4_in),
        .out_valid(o_vld[0]), .out_ready(out_ready), .instruction_out(o_ins[0]),
        .pc_out(o_pc[0]), .pc_plus4_out(o_pc4[0]), .stall_cnt(o_cnt[0])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        in_valid       = v;
        instruction_in = ins;
        pc_in          = pc;
        pc_plus4_in    = pc + 32'd4;
    endtask

    task automatic chk_out(input string tag, input int k, input logic v,
                           input logic [31:0] ins, input logic [31:0] pc);
        chk($sformatf("%s.u%0d.valid", tag, k), o_vld[k], v);
        chk($sformatf("%s.u%0d.instr", tag, k), o_ins[k], v ? ins : PIPE_NOP);
        chk($sformatf("%s.u%0d.pc",    tag, k), o_pc[k],  v ? pc : 32'd0);
        chk($sformatf("%s.u%0d.pc4",   tag, k), o_pc4[k], v ? pc + 32'd4 : 32'd0);
    endtask

    // Scoreboard: the queue holds exactly the entries the stage should be holding.
    for (genvar k = 0; k < 2; k++) begin : g_mon
        payload_t    q[$];
        int unsigned cnt   = 0;
        bit          armed = 1'b0;
        payload_t    exp_p;
        logic        exp_rdy;

        always @(negedge clk) begin
            if (rst) begin
                q.delete();
                cnt   = 0;
                armed = 1'b1;
            end else if (armed) begin
                exp_rdy = (k == 1) ? (q.size() < 2) : (q.size() == 0 || out_ready);
                exp_p   = (q.size() > 0) ? q[0] : '{instr: PIPE_NOP, pc: 32'd0, pc_plus4: 32'd0};
                chk($sformatf("sb%0d.valid", k), o_vld[k], q.size() > 0);
                chk($sformatf("sb%0d.instr", k), o_ins[k], exp_p.instr);
                chk($sformatf("sb%0d.pc",    k), o_pc[k],  exp_p.pc);
                chk($sformatf("sb%0d.pc4",   k), o_pc4[k], exp_p.pc_plus4);
                chk($sformatf("sb%0d.rdy",   k), in_rdy[k], exp_rdy);
                chk($sformatf("sb%0d.cnt",   k), o_cnt[k], cnt);
                if (q.size() > 0 && !out_ready && cnt < 15) cnt++;
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (flush) q.delete();
                else if (in_valid && exp_rdy)
                    q.push_back('{instr: instruction_in, pc: pc_in, pc_plus4: pc_plus4_in});
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 32'h1111_1111, 32'h40);
        step(); step();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            chk_out("reset", k, 1'b0, 32'h0, 32'h0);
            chk($sformatf("reset.u%0d.cnt", k), o_cnt[k], 32'd0);
            chk($sformatf("reset.u%0d.rdy", k), in_rdy[k], 32'd1);
        end

        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'hA0 + i, 32'(4 * i));
            step();
            for (int k = 0; k < 2; k++) chk_out("stream", k, 1'b1, 32'hA0 + i, 32'(4 * i));
        end
        drive(1'b0, 32'h0, 32'h0);
        step();

        out_ready = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 32'h100);
        step();
        drive(1'b1, 32'h00A0_0093, 32'h104);
        step();
        drive(1'b0, 32'h0, 32'h0);
        step(); step();
        for (int k = 0; k < 2; k++) begin
            chk_out("stall", k, 1'b1, 32'hDEAD_BEEF, 32'h100);
            chk($sformatf("stall.u%0d.cnt", k), o_cnt[k], 32'd3);
            chk($sformatf("stall.u%0d.rdy", k), in_rdy[k], 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("stall.rdy_registered", in_rdy[1], 32'd0);
        step();
        chk_out("release1", 1, 1'b1, 32'h00A0_0093, 32'h104);
        chk_out("release1", 0, 1'b0, 32'h0, 32'h0);
        step();
        chk_out("release2", 1, 1'b0, 32'h0, 32'h0);

        out_ready = 1'b0;
        drive(1'b1, 32'h11, 32'h200);
        step();
        drive(1'b1, 32'h22, 32'h204);
        step();
        flush = 1'b1;
        drive(1'b1, 32'hBAD0_0BAD, 32'h300);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            chk_out("flush", k, 1'b0, 32'h0, 32'h0);
            chk($sformatf("flush.u%0d.rdy", k), in_rdy[k], 32'd1);
        end
        out_ready = 1'b1;
        step(); step();
        chk_out("postflush", 1, 1'b0, 32'h0, 32'h0);

        out_ready = 1'b0;
        drive(1'b1, 32'h33, 32'h400);
        step();
        drive(1'b0, 32'h0, 32'h0);
        repeat (20) step();
        for (int k = 0; k < 2; k++) chk($sformatf("sat.u%0d.cnt", k), o_cnt[k], 32'd15);
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 0; k < 2; k++) chk($sformatf("sat_flush.u%0d.cnt", k), o_cnt[k], 32'd15);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) chk($sformatf("sat_rst.u%0d.cnt", k), o_cnt[k], 32'd0);

        for (int c = 0; c < 10000; c++) begin
            drive(1'($urandom), $urandom, $urandom);
            out_ready = 1'($urandom);
            flush     = ($urandom % 16) == 0;
            step();
        end
        drive(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        flush     = 1'b0;
        step(); step(); step();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
